// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor on clkin.
// Sequences PLL reset, waits for stable lock, and releases sys_reset.
module pll_lock_supervisor #(
   parameter int unsigned RST_CYCLES          = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 48000,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       pll_locked,
   output logic       pll_reset,
   output logic       sys_reset,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count,
   output logic [7:0] loss_count
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int SW = (LOCK_STABLE_CYCLES > 1) ?
                       $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ?
                       $clog2(LOCK_TIMEOUT_CYCLES) : 1;

   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ASSERT_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } state_t;

   state_t state_q, state_d;

   logic          sync1_q, sync2_q;
   logic          lock_s;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [SW-1:0] stab_cnt_q, stab_cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic [7:0]    loss_q, loss_d;
   logic          pll_reset_q, pll_reset_d;
   logic          sys_reset_q, sys_reset_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;

   assign lock_s = sync2_q;

   // Next state, counters, and outputs decoded from the current state
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = '0;
      to_cnt_d   = '0;
      stab_cnt_d = '0;
      retry_d    = retry_q;
      loss_d     = loss_q;

      unique case (state_q)
         ASSERT_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            // lock beats a timeout landing on the same cycle
            if (lock_s) begin
               state_d = STABLE;
            end else if (to_cnt_q == TO_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ASSERT_RST;
               end else begin
                  state_d = FAULT;
               end
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         STABLE: begin
            // counts lock_s=1 cycles spent in STABLE
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (stab_cnt_q == STAB_LAST) begin
               state_d = RUN;
            end else begin
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 1'b1;
               end
               retry_d = '0;
               state_d = ASSERT_RST;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = ASSERT_RST;
         end
      endcase

      pll_reset_d = (state_q == ASSERT_RST) || (state_q == FAULT);
      sys_reset_d = (state_q != RUN);
      ready_d     = (state_q == RUN);
      fault_d     = (state_q == FAULT);
   end

   // State, synchronizer, counter and output registers
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= ASSERT_RST;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         rst_cnt_q   <= '0;
         to_cnt_q    <= '0;
         stab_cnt_q  <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_reset_q <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= pll_locked;
         sync2_q     <= sync1_q;
         rst_cnt_q   <= rst_cnt_d;
         to_cnt_q    <= to_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_reset_q <= pll_reset_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset   = pll_reset_q;
   assign sys_reset   = sys_reset_q;
   assign ready       = ready_q;
   assign fault       = fault_q;
   assign retry_count = retry_q;
   assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: scoreboard against a phase model,
// directed bring-up scenarios and randomized lock stimulus.
module tb_pll_lock_supervisor;

   localparam int RST_C  = 4;
   localparam int STAB_C = 8;
   localparam int TO_C   = 32;
   localparam int MAXR   = 2;

   logic       clkin = 1'b0;
   logic       reset;
   logic       pll_locked;
   logic       pll_reset;
   logic       sys_reset;
   logic       ready;
   logic       fault;
   logic [3:0] retry_count;
   logic [7:0] loss_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clkin = ~clkin;

   pll_lock_supervisor #(
      .RST_CYCLES(RST_C),
      .LOCK_STABLE_CYCLES(STAB_C),
      .LOCK_TIMEOUT_CYCLES(TO_C),
      .MAX_RETRIES(MAXR)
   ) dut (
      .clkin(clkin),
      .reset(reset),
      .pll_locked(pll_locked),
      .pll_reset(pll_reset),
      .sys_reset(sys_reset),
      .ready(ready),
      .fault(fault),
      .retry_count(retry_count),
      .loss_count(loss_count)
   );

   // Reference model: bring-up phase plus cycles elapsed in it
   typedef enum {M_RST, M_WAIT, M_STAB, M_RUN, M_FLT} mph_t;
   mph_t m_ph = M_RST;
   int   m_el = 0;
   int   m_retry = 0;
   int   m_loss = 0;
   bit   m_sync[$];
   logic [15:0] exp_q[$];

   function automatic void model_step(input bit r, input bit l);
      bit ls;
      bit o_pll, o_sys, o_rdy, o_flt;
      if (r) begin
         m_ph = M_RST;
         m_el = 0;
         m_retry = 0;
         m_loss = 0;
         m_sync.delete();
         m_sync.push_back(1'b0);
         m_sync.push_back(1'b0);
         o_pll = 1'b1;
         o_sys = 1'b1;
         o_rdy = 1'b0;
         o_flt = 1'b0;
      end else begin
         ls = m_sync.pop_front();
         m_sync.push_back(l);
         o_pll = (m_ph == M_RST) || (m_ph == M_FLT);
         o_sys = (m_ph != M_RUN);
         o_rdy = (m_ph == M_RUN);
         o_flt = (m_ph == M_FLT);
         case (m_ph)
            M_RST: begin
               m_el++;
               if (m_el == RST_C) begin
                  m_ph = M_WAIT;
                  m_el = 0;
               end
            end
            M_WAIT: begin
               if (ls) begin
                  m_ph = M_STAB;
                  m_el = 0;
               end else begin
                  m_el++;
                  if (m_el == TO_C) begin
                     m_el = 0;
                     if (m_retry < MAXR) begin
                        m_retry++;
                        m_ph = M_RST;
                     end else begin
                        m_ph = M_FLT;
                     end
                  end
               end
            end
            M_STAB: begin
               if (!ls) begin
                  m_ph = M_WAIT;
                  m_el = 0;
               end else begin
                  m_el++;
                  if (m_el == STAB_C) begin
                     m_ph = M_RUN;
                     m_el = 0;
                  end
               end
            end
            M_RUN: begin
               if (!ls) begin
                  if (m_loss < 255) m_loss++;
                  m_retry = 0;
                  m_ph = M_RST;
                  m_el = 0;
               end
            end
            default: ;
         endcase
      end
      exp_q.push_back({o_pll, o_sys, o_rdy, o_flt,
                       4'(m_retry), 8'(m_loss)});
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // drive one cycle of stimulus and queue the model's response
   task automatic tick(input bit r, input bit l);
      @(negedge clkin);
      reset = r;
      pll_locked = l;
      model_step(r, l);
   endtask

   task automatic step_obs(input bit r, input bit l);
      tick(r, l);
      @(posedge clkin);
      #1;
   endtask

   // Monitor: every output update is popped and compared
   logic [15:0] act_v;
   logic [15:0] exp_v;
   initial begin
      forever begin
         @(posedge clkin);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pll_reset, sys_reset, ready, fault,
                     retry_count, loss_count};
            n_chk++;
            if (act_v !== exp_v) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t got %h expected %h",
                        $time, act_v, exp_v);
            end
         end
      end
   end

   int n;
   int m;
   int highs;
   int len;
   bit lvl;

   initial begin
      reset = 1'b1;
      pll_locked = 1'b0;

      // reset values
      step_obs(1, 1);
      step_obs(1, 1);
      chk("rst_pll_reset", pll_reset, 1);
      chk("rst_sys_reset", sys_reset, 1);
      chk("rst_ready", ready, 0);
      chk("rst_fault", fault, 0);
      chk("rst_retry", retry_count, 0);
      chk("rst_loss", loss_count, 0);

      // nominal bring-up
      n = 0;
      highs = 0;
      do begin
         step_obs(0, 1);
         n++;
         if (pll_reset) highs++;
      end while (!ready && n < 100);
      chk("nominal_ready_cycle", n, 14);
      chk("nominal_pll_pulse", highs, 4);
      chk("nominal_sys_reset", sys_reset, 0);
      chk("nominal_retry", retry_count, 0);

      // one-cycle glitch at stable count 5
      step_obs(1, 1);
      n = 0;
      do begin
         n++;
         step_obs(0, n != 9);
      end while (!ready && n < 100);
      chk("glitch_ready_cycle", n, 21);
      chk("glitch_retry", retry_count, 0);

      // first attempt times out, second locks
      step_obs(1, 0);
      n = 0;
      highs = 0;
      do begin
         n++;
         step_obs(0, n >= 37);
         if (pll_reset) highs++;
      end while (!ready && n < 200);
      chk("timeout_ready_cycle", n, 50);
      chk("timeout_pll_pulses", highs, 8);
      chk("timeout_retry", retry_count, 1);

      // never locks: fault after MAXR retries
      step_obs(1, 0);
      n = 0;
      do begin
         n++;
         step_obs(0, 0);
      end while (!fault && n < 300);
      chk("fault_cycle", n, 109);
      chk("fault_retry", retry_count, 2);
      chk("fault_pll_reset", pll_reset, 1);
      repeat (5) step_obs(0, 1);
      chk("fault_sticky", fault, 1);
      step_obs(1, 1);
      chk("fault_cleared", fault, 0);
      chk("fault_rst_pll", pll_reset, 1);
      chk("fault_rst_retry", retry_count, 0);

      // lock losses from RUN, through saturation
      step_obs(1, 1);
      for (int k = 0; k < 300; k++) begin
         n = 0;
         while (!ready && n < 60) begin
            step_obs(0, 1);
            n++;
         end
         if (!ready) chk("loss_relock_timeout", 0, 1);
         step_obs(0, 0);
         m = 1;
         while (!sys_reset && m < 10) begin
            step_obs(0, 1);
            m++;
         end
         if (k == 0) begin
            chk("loss_sys_reset_latency", m, 4);
            chk("loss_count_first", loss_count, 1);
            chk("loss_ready", ready, 0);
            chk("loss_retry", retry_count, 0);
         end
      end
      chk("loss_saturated", loss_count, 255);

      // randomized lock behaviour with occasional resets
      step_obs(1, 1);
      for (int s = 0; s < 250; s++) begin
         lvl = ($urandom_range(0, 3) != 0);
         len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 45);
         for (int i = 0; i < len; i++) begin
            tick($urandom_range(0, 199) == 0, lvl);
         end
      end

      repeat (3) @(posedge clkin);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
